regfile_arbiter: RTL and testbench

REGFILE_ARBITER -- requirements
Module: regfile_arbiter

---
 rtl/regfile_pkg.sv | 48 ++++
 rtl/rr_arbiter2.sv | 34 +++
 rtl/regfile_arbiter.sv | 177 +++++++++++++++++
 tb/tb_regfile_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants, FSM encoding and command payload for the register-file arbiter.
package regfile_pkg;

  localparam int unsigned ADDR_DEPTH_DEF = 64;
  localparam int unsigned RD_LATENCY_DEF = 2;
  localparam int unsigned NUM_REQ        = 2;
  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned CNT_W          = 3;

  // Requester indices
  localparam int unsigned REQ_UART = 0;
  localparam int unsigned REQ_DBG  = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // Extract the granted requester's command from the packed per-requester buses.
  function automatic cmd_t pick_cmd(
    input logic [NUM_REQ-1:0]        grant,
    input logic [NUM_REQ-1:0]        write,
    input logic [NUM_REQ*ADDR_W-1:0] addr,
    input logic [NUM_REQ*DATA_W-1:0] wdata
  );
    cmd_t c;
    if (grant[REQ_DBG]) begin
      c.write = write[REQ_DBG];
      c.addr  = addr[REQ_DBG*ADDR_W +: ADDR_W];
      c.wdata = wdata[REQ_DBG*DATA_W +: DATA_W];
    end else begin
      c.write = write[REQ_UART];
      c.addr  = addr[REQ_UART*ADDR_W +: ADDR_W];
      c.wdata = wdata[REQ_UART*DATA_W +: DATA_W];
    end
    return c;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: a lone request always wins, ties go to the
// requester that was not granted last; bit0 wins the first tie after reset.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

  // 1 means bit1 wins the next tie
  logic prio;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = prio ? 2'b10 : 2'b01;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (advance && (|grant)) begin
      prio <= grant[REQ_UART];
    end
  end

endmodule

// File: rtl/regfile_arbiter.sv
// Serialises register-file accesses from the UART parser and the debug port:
// one command in flight, fixed read latency, one response pulse per command.
module regfile_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH = ADDR_DEPTH_DEF,
  parameter int unsigned RD_LATENCY = RD_LATENCY_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rf_we,
  output logic                      rf_re,
  output logic [ADDR_W-1:0]         rf_w_addr,
  output logic [ADDR_W-1:0]         rf_r_addr,
  output logic [DATA_W-1:0]         rf_w_data,
  input  logic [DATA_W-1:0]         rf_r_data,
  input  logic                      rf_status,
  output logic                      busy
);

  state_e             state, state_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] owner, owner_nxt;
  cmd_t               cmd, cmd_nxt;
  logic               range_err, range_err_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]  cap_data, cap_data_nxt;
  logic               cap_status, cap_status_nxt;
  logic               in_range;
  logic               wait_done;

  logic [NUM_REQ-1:0] req_ready_nxt;
  logic [NUM_REQ-1:0] rsp_valid_nxt;
  logic [DATA_W-1:0]  rsp_rdata_nxt;
  logic               rsp_err_nxt;
  logic               rf_we_nxt;
  logic               rf_re_nxt;
  logic [ADDR_W-1:0]  rf_w_addr_nxt;
  logic [ADDR_W-1:0]  rf_r_addr_nxt;
  logic [DATA_W-1:0]  rf_w_data_nxt;
  logic               busy_nxt;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req_valid),
    .advance (state == ST_IDLE),
    .grant   (grant)
  );

  assign in_range  = 32'(cmd.addr) < ADDR_DEPTH;
  // WAIT covers the strobe cycle plus RD_LATENCY cycles of register-file latency
  assign wait_done = (cnt == CNT_W'(RD_LATENCY));

  // State register; every output and datapath register is loaded alongside it
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      owner      <= '0;
      cmd        <= '0;
      range_err  <= 1'b0;
      cnt        <= '0;
      cap_data   <= '0;
      cap_status <= 1'b0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      rf_we      <= 1'b0;
      rf_re      <= 1'b0;
      rf_w_addr  <= '0;
      rf_r_addr  <= '0;
      rf_w_data  <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      cmd        <= cmd_nxt;
      range_err  <= range_err_nxt;
      cnt        <= cnt_nxt;
      cap_data   <= cap_data_nxt;
      cap_status <= cap_status_nxt;
      req_ready  <= req_ready_nxt;
      rsp_valid  <= rsp_valid_nxt;
      rsp_rdata  <= rsp_rdata_nxt;
      rsp_err    <= rsp_err_nxt;
      rf_we      <= rf_we_nxt;
      rf_re      <= rf_re_nxt;
      rf_w_addr  <= rf_w_addr_nxt;
      rf_r_addr  <= rf_r_addr_nxt;
      rf_w_data  <= rf_w_data_nxt;
      busy       <= busy_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (|req_valid) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = in_range ? ST_WAIT : ST_RESP;
      ST_WAIT:  if (wait_done) state_nxt = ST_RESP;
      ST_RESP:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the command datapath
  always_comb begin
    owner_nxt      = owner;
    cmd_nxt        = cmd;
    range_err_nxt  = range_err;
    cnt_nxt        = cnt;
    cap_data_nxt   = cap_data;
    cap_status_nxt = cap_status;
    req_ready_nxt  = '0;
    rsp_valid_nxt  = '0;
    rsp_rdata_nxt  = rsp_rdata;
    rsp_err_nxt    = rsp_err;
    rf_we_nxt      = 1'b0;
    rf_re_nxt      = 1'b0;
    rf_w_addr_nxt  = rf_w_addr;
    rf_r_addr_nxt  = rf_r_addr;
    rf_w_data_nxt  = rf_w_data;
    busy_nxt       = (state_nxt != ST_IDLE);

    case (state)
      ST_IDLE: begin
        if (|req_valid) begin
          req_ready_nxt = grant;
          owner_nxt     = grant;
          cmd_nxt       = pick_cmd(grant, req_write, req_addr, req_wdata);
          range_err_nxt = 1'b0;
        end
      end
      ST_ISSUE: begin
        cnt_nxt = '0;
        if (in_range) begin
          if (cmd.write) begin
            rf_we_nxt     = 1'b1;
            rf_w_addr_nxt = cmd.addr;
            rf_w_data_nxt = cmd.wdata;
          end else begin
            rf_re_nxt     = 1'b1;
            rf_r_addr_nxt = cmd.addr;
          end
        end else begin
          range_err_nxt = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (wait_done) begin
          cap_data_nxt   = rf_r_data;
          cap_status_nxt = rf_status;
        end
      end
      ST_RESP: begin
        rsp_valid_nxt = owner;
        rsp_err_nxt   = range_err | ~cap_status;
        rsp_rdata_nxt = (!range_err && cap_status && !cmd.write) ? cap_data : '0;
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Randomized bench for regfile_arbiter: two queue-driven requesters, a
// register-file stub that returns data only in the exact capture cycle, and a
// transaction-level reference model predicting grants, strobes and responses.
module tb_regfile_arbiter;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned RDL     = 3;
  localparam logic [7:0]  HOLE_LO = 8'h30;
  localparam logic [7:0]  HOLE_HI = 8'h37;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic        rf_we;
  logic        rf_re;
  logic [7:0]  rf_w_addr;
  logic [7:0]  rf_r_addr;
  logic [7:0]  rf_w_data;
  logic [7:0]  rf_r_data;
  logic        rf_status;
  logic        busy;

  always #5 clk = ~clk;

  regfile_arbiter #(.ADDR_DEPTH(DEPTH), .RD_LATENCY(RDL)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .rf_we     (rf_we),
    .rf_re     (rf_re),
    .rf_w_addr (rf_w_addr),
    .rf_r_addr (rf_r_addr),
    .rf_w_data (rf_w_data),
    .rf_r_data (rf_r_data),
    .rf_status (rf_status),
    .busy      (busy)
  );

  typedef struct packed {
    logic       write;
    logic [7:0] addr;
    logic [7:0] wdata;
  } cmd_s;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester command queues
  cmd_s q0[$];
  cmd_s q1[$];
  int   gap[2];
  bit   rand_mode;

  function automatic cmd_s mk(input logic w, input logic [7:0] a, input logic [7:0] d);
    cmd_s c;
    c.write = w;
    c.addr  = a;
    c.wdata = d;
    return c;
  endfunction

  function automatic cmd_s q_front(input int n);
    if (n == 0) return (q0.size() != 0) ? q0[0] : '0;
    return (q1.size() != 0) ? q1[0] : '0;
  endfunction

  function automatic bit in_hole(input logic [7:0] a);
    return (a >= HOLE_LO) && (a <= HOLE_HI);
  endfunction

  // Reference model state
  int         cyc;
  bit         act;
  int         g_cyc;
  int         resp_cyc;
  int         owner;
  cmd_s       cur;
  bit         cur_in;
  logic       exp_err;
  logic [7:0] exp_rdata;
  logic       last_err;
  logic [7:0] last_rdata;
  logic [1:0] exp_ready_nxt;
  int         last_grant;
  bit         rst_chk;
  int         grant_log[$];
  logic [7:0] ref_mem[256];

  // Register-file stub state
  logic [7:0] rf_mem[256];
  bit         strobe_pend;
  int         strobe_k;
  logic [7:0] strobe_addr;

  function automatic logic [1:0] arb(input logic [1:0] v);
    if (v == 2'b11) return (last_grant == 0) ? 2'b10 : 2'b01;
    return v;
  endfunction

  // One clock cycle: check outputs at the falling edge, then drive next inputs.
  task automatic step(input bit do_reset);
    logic [1:0] rdy;
    logic [1:0] v;
    logic [1:0] exp_rsp;
    cmd_s       f0, f1;
    bit         exp_we, exp_re, hole;
    @(negedge clk);
    cyc++;
    rdy = req_ready;
    f0  = q_front(0);
    f1  = q_front(1);

    check("req_ready", 32'(rdy), 32'(exp_ready_nxt));
    if (exp_ready_nxt != 2'b00) begin
      owner    = exp_ready_nxt[1] ? 1 : 0;
      cur      = (owner == 1) ? f1 : f0;
      act      = 1'b1;
      g_cyc    = cyc;
      last_grant = owner;
      grant_log.push_back(owner);
      cur_in   = 32'(cur.addr) < DEPTH;
      hole     = in_hole(cur.addr);
      resp_cyc = cyc + (cur_in ? 3 + int'(RDL) : 2);
      exp_err  = !cur_in || hole;
      exp_rdata = (!exp_err && !cur.write) ? ref_mem[cur.addr] : 8'h00;
      if (cur_in && !hole && cur.write) ref_mem[cur.addr] = cur.wdata;
    end

    check("busy", 32'(busy), 32'(act && (cyc < resp_cyc)));

    exp_we = act && (cyc == g_cyc + 1) && cur_in && cur.write;
    exp_re = act && (cyc == g_cyc + 1) && cur_in && !cur.write;
    check("rf_we", 32'(rf_we), 32'(exp_we));
    check("rf_re", 32'(rf_re), 32'(exp_re));
    if (exp_we) begin
      check("rf_w_addr", 32'(rf_w_addr), 32'(cur.addr));
      check("rf_w_data", 32'(rf_w_data), 32'(cur.wdata));
    end
    if (exp_re) check("rf_r_addr", 32'(rf_r_addr), 32'(cur.addr));

    exp_rsp = (act && (cyc == resp_cyc)) ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
    check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    if (exp_rsp != 2'b00) begin
      last_err   = exp_err;
      last_rdata = exp_rdata;
      act        = 1'b0;
    end
    check("rsp_err", 32'(rsp_err), 32'(last_err));
    check("rsp_rdata", 32'(rsp_rdata), 32'(last_rdata));

    if (rst_chk) begin
      check("rst_rf_w_addr", 32'(rf_w_addr), 32'h0);
      check("rst_rf_r_addr", 32'(rf_r_addr), 32'h0);
      check("rst_rf_w_data", 32'(rf_w_data), 32'h0);
      rst_chk = 1'b0;
    end

    // Register-file stub: data and good status only in the capture cycle
    if (rf_we && !in_hole(rf_w_addr)) rf_mem[rf_w_addr] = rf_w_data;
    if (rf_we || rf_re) begin
      strobe_pend = 1'b1;
      strobe_k    = cyc;
      strobe_addr = rf_we ? rf_w_addr : rf_r_addr;
    end
    if (strobe_pend && (cyc == strobe_k + int'(RDL))) begin
      rf_r_data   = rf_mem[strobe_addr];
      rf_status   = !in_hole(strobe_addr);
      strobe_pend = 1'b0;
    end else begin
      rf_r_data = 8'($urandom);
      rf_status = 1'b0;
    end

    // Requesters hold each command until accepted, then maybe idle a while
    if (rdy[0] && q0.size() != 0) begin
      void'(q0.pop_front());
      gap[0] = rand_mode ? int'($urandom_range(3, 0)) : 0;
    end
    if (rdy[1] && q1.size() != 0) begin
      void'(q1.pop_front());
      gap[1] = rand_mode ? int'($urandom_range(3, 0)) : 0;
    end
    v[0] = (q0.size() != 0) && (gap[0] == 0);
    v[1] = (q1.size() != 0) && (gap[1] == 0);
    for (int n = 0; n < 2; n++) if (gap[n] > 0) gap[n]--;
    f0 = q_front(0);
    f1 = q_front(1);
    req_valid = v;
    req_write = {f1.write, f0.write};
    req_addr  = {f1.addr, f0.addr};
    req_wdata = {f1.wdata, f0.wdata};
    reset     = !do_reset;

    if (do_reset) begin
      act           = 1'b0;
      exp_ready_nxt = 2'b00;
      last_grant    = 1;
      last_err      = 1'b0;
      last_rdata    = 8'h00;
      strobe_pend   = 1'b0;
      rst_chk       = 1'b1;
    end else begin
      exp_ready_nxt = act ? 2'b00 : arb(v);
    end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (!(q0.size() == 0 && q1.size() == 0 && !act && exp_ready_nxt == 2'b00) && i < budget) begin
      step(1'b0);
      i++;
    end
    check("drain_timeout", 32'(i >= budget), 32'h0);
  endtask

  initial begin
    logic [7:0] a;
    int         r;
    for (int i = 0; i < 256; i++) begin
      ref_mem[i] = 8'h00;
      rf_mem[i]  = 8'h00;
    end
    cyc = 0; act = 1'b0; g_cyc = 0; resp_cyc = 0; owner = 0; cur = '0; cur_in = 1'b0;
    exp_err = 1'b0; exp_rdata = 8'h00; last_err = 1'b0; last_rdata = 8'h00;
    exp_ready_nxt = 2'b00; last_grant = 1; rst_chk = 1'b1; rand_mode = 1'b0;
    gap[0] = 0; gap[1] = 0; strobe_pend = 1'b0; strobe_k = 0; strobe_addr = 8'h00;
    reset = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    rf_r_data = '0; rf_status = 1'b0;
    repeat (2) @(posedge clk);
    step(1'b1);
    step(1'b0);

    // Write then read back through the other requester
    q0.push_back(mk(1'b1, 8'h05, 8'hA5));
    drain(200);
    q1.push_back(mk(1'b0, 8'h05, 8'h00));
    drain(200);

    // Both requesters continuously valid after reset: grants alternate from 0
    step(1'b1);
    step(1'b0);
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back(mk(1'b0, 8'(i), 8'h00));
      q1.push_back(mk(1'b0, 8'(i + 8), 8'h00));
    end
    drain(400);
    check("alt_count", 32'(grant_log.size()), 32'd8);
    for (int i = 0; i < grant_log.size(); i++) check("alt_order", 32'(grant_log[i]), 32'(i % 2));

    // Out-of-range write and an unmapped in-range read
    q0.push_back(mk(1'b1, 8'h40, 8'h77));
    drain(200);
    q1.push_back(mk(1'b0, 8'h33, 8'h00));
    drain(200);

    // Reset while waiting on the register file aborts the command
    q0.push_back(mk(1'b0, 8'h05, 8'h00));
    for (int i = 0; i < 100 && !(act && cyc == g_cyc + 2); i++) step(1'b0);
    check("reach_wait", 32'(act && cyc == g_cyc + 2), 32'h1);
    step(1'b1);
    step(1'b0);
    q0.push_back(mk(1'b1, 8'h06, 8'h3C));
    q0.push_back(mk(1'b0, 8'h06, 8'h00));
    drain(300);

    // Random traffic with idle gaps, holes and out-of-range addresses
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(99, 0));
      if (r < 70)      a = 8'($urandom_range(63, 0));
      else if (r < 85) a = 8'($urandom_range(32'(HOLE_HI), 32'(HOLE_LO)));
      else             a = 8'($urandom_range(255, 64));
      if (i % 2 == 0) q0.push_back(mk(1'($urandom_range(1, 0)), a, 8'($urandom)));
      else            q1.push_back(mk(1'($urandom_range(1, 0)), a, 8'($urandom)));
    end
    drain(20000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
